// File: rtl/or_chk_pkg.sv
// Shared definitions for the quad 2-input OR device checker.
// Holds the controller state encoding and the sizing constants for
// the four gates, the four truth-table vectors and the error counter.
package or_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int NUM_GATES = 4;
  localparam int NUM_VECS  = 4;
  localparam int ERR_W     = 4;
  localparam int ERR_MAX   = 15;

endpackage

// File: rtl/or_gate_vector_checker_hold_timer.sv
// hold_timer: up-counter that marks the last cycle of a hold window.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset, count -> 0
//   clr  - synchronous clear, count -> 0 (has priority over en)
//   en   - count enable
//   tc   - terminal count, high while count == HOLD_CYCLES-1
module hold_timer #(
  parameter int HOLD_CYCLES = 10,
  parameter int CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  // With HOLD_CYCLES=1 the count never leaves 0, so tc is high on every
  // enabled cycle and each vector is sampled the cycle it is driven.
  assign tc = (count == LAST);

endmodule

// File: rtl/or_gate_vector_checker.sv
// or_gate_vector_checker: drives the four A/B pairs of a quad 2-input OR
// device through the full 2-bit truth table, samples the Y outputs at the
// end of each hold window and accumulates per-gate fail flags and a
// saturating mismatch count.
// Ports:
//   i_clk        - clock, rising edge
//   i_reset      - synchronous active-high reset, discards any run
//   i_start      - start a run (honoured in IDLE or DONE only)
//   i_y[3:0]     - device outputs, bit n = gate n+1
//   o_a, o_b     - registered A/B inputs to gates 1..4
//   o_vec        - current vector index {A,B}
//   o_busy       - run in progress
//   o_done       - run finished, results valid
//   o_pass       - done with no mismatch
//   o_fail_mask  - sticky per-gate mismatch flags
//   o_err_count  - mismatching gate-samples, saturating at 15
module or_gate_vector_checker
  import or_chk_pkg::*;
#(
  parameter int HOLD_CYCLES = 10
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [NUM_GATES-1:0] i_y,
  output logic [NUM_GATES-1:0] o_a,
  output logic [NUM_GATES-1:0] o_b,
  output logic [1:0]           o_vec,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_pass,
  output logic [NUM_GATES-1:0] o_fail_mask,
  output logic [ERR_W-1:0]     o_err_count
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam int PC_W  = $clog2(NUM_GATES + 1);

  function automatic logic [PC_W-1:0] popcount(input logic [NUM_GATES-1:0] v);
    logic [PC_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_GATES; i++) begin
      n = n + PC_W'(v[i]);
    end
    return n;
  endfunction

  function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] acc,
                                               input logic [PC_W-1:0]  inc);
    logic [ERR_W:0] s;
    s = {1'b0, acc} + (ERR_W + 1)'(inc);
    if (s > (ERR_W + 1)'(ERR_MAX)) begin
      return ERR_W'(ERR_MAX);
    end
    return s[ERR_W-1:0];
  endfunction

  state_t               state;
  logic                 tc;
  logic [NUM_GATES-1:0] expected;
  logic [NUM_GATES-1:0] mism;
  logic [NUM_GATES-1:0] mask_next;
  logic [ERR_W-1:0]     err_next;
  logic [1:0]           vec_next;

  // Expected response comes from the registered A/B currently applied, so
  // the comparison is against exactly what the device is seeing.
  assign expected  = o_a | o_b;
  assign mism      = expected ^ i_y;
  assign mask_next = o_fail_mask | mism;
  assign err_next  = sat_add(o_err_count, popcount(mism));
  assign vec_next  = o_vec + 2'd1;

  hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES),
    .CNT_W       (CNT_W)
  ) u_hold_timer (
    .clk (i_clk),
    .rst (i_reset),
    .clr (tc),
    .en  (state == DRIVE),
    .tc  (tc)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= IDLE;
      o_a         <= '0;
      o_b         <= '0;
      o_vec       <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_pass      <= 1'b0;
      o_fail_mask <= '0;
      o_err_count <= '0;
    end else begin
      case (state)
        // A start from DONE behaves exactly like one from IDLE and wipes
        // the previous results.
        IDLE, DONE: begin
          if (i_start) begin
            state       <= DRIVE;
            o_a         <= '0;
            o_b         <= '0;
            o_vec       <= '0;
            o_busy      <= 1'b1;
            o_done      <= 1'b0;
            o_pass      <= 1'b0;
            o_fail_mask <= '0;
            o_err_count <= '0;
          end
        end
        DRIVE: begin
          if (tc) begin
            o_fail_mask <= mask_next;
            o_err_count <= err_next;
            if (o_vec == 2'(NUM_VECS - 1)) begin
              state  <= DONE;
              o_busy <= 1'b0;
              o_done <= 1'b1;
              o_pass <= (mask_next == '0);
              o_a    <= '0;
              o_b    <= '0;
              o_vec  <= '0;
            end else begin
              o_vec <= vec_next;
              o_a   <= {NUM_GATES{vec_next[1]}};
              o_b   <= {NUM_GATES{vec_next[0]}};
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_or_gate_vector_checker.sv
// Bench for or_gate_vector_checker: a behavioural device model (OR, stuck
// faults, AND, NOR, random per-vector bit flips) feeds i_y, and a
// truth-table reference computes the expected mask, count and pass flag.
module tb_or_gate_vector_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start10, start1;
  logic [3:0]  y10, y1;
  logic [3:0]  a10, b10, a1, b1, mask10, mask1, err10, err1;
  logic [1:0]  vec10, vec1;
  logic        busy10, busy1, done10, done1, pass10, pass1;

  int          mode;
  logic [15:0] flips;
  int          tests = 0;
  int          fails = 0;

  or_gate_vector_checker #(.HOLD_CYCLES(10)) dut10 (
    .i_clk(clk), .i_reset(rst), .i_start(start10), .i_y(y10),
    .o_a(a10), .o_b(b10), .o_vec(vec10), .o_busy(busy10), .o_done(done10),
    .o_pass(pass10), .o_fail_mask(mask10), .o_err_count(err10));

  or_gate_vector_checker #(.HOLD_CYCLES(1)) dut1 (
    .i_clk(clk), .i_reset(rst), .i_start(start1), .i_y(y1),
    .o_a(a1), .o_b(b1), .o_vec(vec1), .o_busy(busy1), .o_done(done1),
    .o_pass(pass1), .o_fail_mask(mask1), .o_err_count(err1));

  // Device under test behaviour, selected by mode.
  function automatic logic [3:0] dev(input int m, input logic [3:0] a,
                                     input logic [3:0] b, input logic [15:0] f);
    logic [1:0] idx;
    idx = {a[0], b[0]};
    case (m)
      1:       return (a | b) & 4'b1011;          // gate 3 stuck-at-0
      2:       return 4'hF;                        // all stuck-at-1
      3:       return a & b;                       // AND device
      4:       return ~(a | b);                    // NOR device
      5:       return (a | b) ^ f[4*idx +: 4];     // random flips per vector
      default: return a | b;                       // good OR device
    endcase
  endfunction

  assign y10 = dev(mode, a10, b10, flips);
  assign y1  = dev(mode, a1, b1, flips);

  // Selected-instance view
  logic       sel;
  logic [3:0] a_m, b_m, mask_m, err_m;
  logic [1:0] vec_m;
  logic       busy_m, done_m, pass_m;
  always_comb begin
    a_m = sel ? a1 : a10;       b_m = sel ? b1 : b10;
    mask_m = sel ? mask1 : mask10; err_m = sel ? err1 : err10;
    vec_m = sel ? vec1 : vec10; busy_m = sel ? busy1 : busy10;
    done_m = sel ? done1 : done10; pass_m = sel ? pass1 : pass10;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel) start1 = v; else start10 = v;
  endtask

  // Reference: walk the truth table, compare device output with A|B.
  task automatic model(input int m, input logic [15:0] f,
                       output logic [3:0] emask, output int eerr);
    emask = '0;
    eerr  = 0;
    for (int v = 0; v < 4; v++) begin
      logic [3:0] av, bv, mm;
      av = (v >= 2) ? 4'hF : 4'h0;
      bv = (v % 2 == 1) ? 4'hF : 4'h0;
      mm = dev(m, av, bv, f) ^ (av | bv);
      emask |= mm;
      eerr  += $countones(mm);
    end
    if (eerr > 15) eerr = 15;
  endtask

  task automatic run(input string tag, input int hold, input int m,
                     input bit inject);
    logic [3:0] emask;
    int         eerr, k, bad, ev;
    mode = m;
    model(m, flips, emask, eerr);
    @(negedge clk); set_start(1'b1);
    @(negedge clk); set_start(1'b0);
    chk({tag, "_busy0"}, busy_m, 1);
    chk({tag, "_cleared"}, {done_m, pass_m, mask_m, err_m}, 0);
    k = 0; bad = 0;
    while (busy_m && k < 400) begin
      ev = k / hold;
      if (vec_m !== 2'(ev) || a_m !== {4{ev >= 2}} || b_m !== {4{ev % 2 == 1}}) bad++;
      set_start(inject && k == 15);
      @(negedge clk);
      k++;
    end
    set_start(1'b0);
    chk({tag, "_busy_len"}, k, 4 * hold);
    chk({tag, "_vec_seq"}, bad, 0);
    chk({tag, "_done"}, done_m, 1);
    chk({tag, "_pass"}, pass_m, emask == 0);
    chk({tag, "_mask"}, mask_m, emask);
    chk({tag, "_err"}, err_m, eerr);
    chk({tag, "_ab_idle"}, {a_m, b_m, vec_m}, 0);
    repeat (3) @(negedge clk);
    chk({tag, "_hold"}, {busy_m, done_m, mask_m, err_m}, {1'b0, 1'b1, emask, 4'(eerr)});
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start10 = 1'b0; start1 = 1'b0; sel = 1'b0;
    mode = 0; flips = '0;
    repeat (3) @(negedge clk);
    chk("reset10", {a10, b10, vec10, busy10, done10, pass10, mask10, err10}, 0);
    chk("reset1",  {a1, b1, vec1, busy1, done1, pass1, mask1, err1}, 0);
    rst = 1'b0;
    @(negedge clk);

    run("good", 10, 0, 1'b0);
    run("g3_sa0", 10, 1, 1'b0);
    run("all_sa1", 10, 2, 1'b0);
    run("and_dev", 10, 3, 1'b0);
    run("nor_dev", 10, 4, 1'b0);
    run("restart_midstart", 10, 0, 1'b1);
    for (int r = 0; r < 3; r++) begin
      flips = 16'($urandom);
      if (r == 0) flips = flips & 16'($urandom) & 16'($urandom);
      run($sformatf("rand%0d", r), 10, 5, 1'b0);
    end

    // Reset in the middle of a run with faults already recorded.
    mode = 4;
    @(negedge clk); start10 = 1'b1;
    @(negedge clk); start10 = 1'b0;
    repeat (15) @(negedge clk);
    chk("pre_reset_busy", busy10, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_reset", {a10, b10, vec10, busy10, done10, pass10, mask10, err10}, 0);
    repeat (3) @(negedge clk);
    chk("post_reset_idle", {busy10, done10}, 0);

    sel = 1'b1;
    flips = '0;
    run("h1_good", 1, 0, 1'b0);
    run("h1_nor", 1, 4, 1'b0);
    flips = 16'($urandom);
    run("h1_rand", 1, 5, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
